uart_tx_arbiter: RTL and testbench

//   Shares one UART transmitter between NUM_REQ byte-stream requesters.

---
 rtl/uart_tx_arbiter.sv | 129 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Summary  : Round-robin, packet-granular sharing of one UART TX between
//            NUM_REQ byte-stream requesters.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int  NUM_REQ = 4,
    parameter int  DATA_W  = 8,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [DATA_W-1:0]         tx_data,
    output logic                      tx_start,
    input  logic                      tx_busy,
    output logic [ID_W-1:0]           grant_id,
    output logic                      active
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    localparam logic [ID_W-1:0] c_LAST_ID = ID_W'(NUM_REQ - 1);
    localparam logic [ID_W:0]   c_NUM_REQ = (ID_W+1)'(NUM_REQ);

    state_t            r_state_q, w_state_d;
    logic [ID_W-1:0]   r_rr_ptr_q, w_rr_ptr_d;
    logic [ID_W-1:0]   r_grant_q, w_grant_d;
    logic              r_last_q, w_last_d;

    logic              w_any_valid;
    logic [ID_W-1:0]   w_winner;
    logic [DATA_W-1:0] w_bytes [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign w_bytes[gi] = req_data[gi*DATA_W +: DATA_W];
    end

    // Scan from the far end back towards rr_ptr so the closest valid index wins.
    always_comb begin
        logic [ID_W:0] w_sum;
        w_winner    = r_rr_ptr_q;
        w_any_valid = 1'b0;
        w_sum       = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, r_rr_ptr_q} + (ID_W+1)'(k);
            if (w_sum >= c_NUM_REQ) begin
                w_sum = w_sum - c_NUM_REQ;
            end
            if (req_valid[w_sum[ID_W-1:0]]) begin
                w_winner    = w_sum[ID_W-1:0];
                w_any_valid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q  <= S_IDLE;
            r_rr_ptr_q <= '0;
            r_grant_q  <= '0;
            r_last_q   <= 1'b0;
        end else begin
            r_state_q  <= w_state_d;
            r_rr_ptr_q <= w_rr_ptr_d;
            r_grant_q  <= w_grant_d;
            r_last_q   <= w_last_d;
        end
    end

    always_comb begin
        w_state_d  = r_state_q;
        w_rr_ptr_d = r_rr_ptr_q;
        w_grant_d  = r_grant_q;
        w_last_d   = r_last_q;
        req_ready  = '0;
        tx_start   = 1'b0;
        tx_data    = '0;
        case (r_state_q)
            S_IDLE: begin
                if (w_any_valid) begin
                    w_grant_d = w_winner;
                    w_state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // The owner keeps the lock even while its valid is low.
                if (req_valid[r_grant_q]) begin
                    req_ready[r_grant_q] = 1'b1;
                    tx_start             = 1'b1;
                    tx_data              = w_bytes[r_grant_q];
                    w_last_d             = req_last[r_grant_q];
                    w_state_d            = S_WAIT_BUSY;
                end
            end
            S_WAIT_BUSY: begin
                if (tx_busy) begin
                    w_state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    if (r_last_q) begin
                        w_rr_ptr_d = (r_grant_q == c_LAST_ID) ? '0 : r_grant_q + 1'b1;
                        w_state_d  = S_IDLE;
                    end else begin
                        w_state_d  = S_ISSUE;
                    end
                end
            end
            default: w_state_d = S_IDLE;
        endcase
    end

    assign grant_id = r_grant_q;
    assign active   = (r_state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Summary  : Self-checking bench for uart_tx_arbiter with a packet-level
//            round-robin reference model and a 10-cycle UART TX model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int NR    = 4;
    localparam int DW    = 8;
    localparam int IDW   = 2;
    localparam int DEPTH = 256;
    localparam int BUSY  = 10;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [NR-1:0]  req_valid = '0;
    logic [NR*DW-1:0] req_data = '0;
    logic [NR-1:0]  req_last = '0;
    logic [NR-1:0]  req_ready;
    logic [DW-1:0]  tx_data;
    logic           tx_start;
    logic           tx_busy = 1'b0;
    logic [IDW-1:0] grant_id;
    logic           active;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(NR), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_busy   (tx_busy),
        .grant_id  (grant_id),
        .active    (active)
    );

    int checks   = 0;
    int failures = 0;

    // Per-requester byte FIFOs: {last, data}
    logic [8:0] mem [NR][DEPTH];
    int head [NR];
    int tail [NR];

    // Reference model: packet owner (-1 none) and round-robin pointer
    int owner = -1;
    int rr    = 0;

    int busy_cnt   = 0;
    bit frame_open = 1'b0;
    int stall_cnt [NR];
    int stall_req  = -1;
    int stall_len  = 0;
    bit stall_pend = 1'b0;
    int stall_starts = 0;

    int log_id [$];
    int exp_ids [$];

    logic           o_start;
    logic [DW-1:0]  o_data;
    logic [NR-1:0]  o_ready;
    logic [IDW-1:0] o_grant;
    logic           o_active;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int i, input logic [7:0] d, input logic l);
        mem[i][tail[i]] = {l, d};
        tail[i]++;
    endtask

    function automatic bit pending();
        bit p = 1'b0;
        for (int i = 0; i < NR; i++) if (head[i] != tail[i]) p = 1'b1;
        return p;
    endfunction

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            logic [8:0] e;
            e = mem[i][head[i]];
            if (!rst && head[i] != tail[i] && stall_cnt[i] == 0) begin
                req_valid[i]         = 1'b1;
                req_data[i*DW +: DW] = e[7:0];
                req_last[i]          = e[8];
            end else begin
                req_valid[i]         = 1'b0;
                req_data[i*DW +: DW] = '0;
                req_last[i]          = 1'b0;
            end
        end
    endtask

    task automatic clear_state();
        for (int i = 0; i < NR; i++) begin
            head[i] = 0; tail[i] = 0; stall_cnt[i] = 0;
        end
        owner = -1; rr = 0; busy_cnt = 0; frame_open = 1'b0;
        tx_busy = 1'b0; stall_pend = 1'b0; stall_req = -1;
        log_id.delete();
    endtask

    // One clock: observe at negedge, then update UART model and requesters after posedge.
    task automatic step();
        logic [NR-1:0] hs;
        logic [8:0]    ent;
        int g, e, idx;
        bit fell;
        @(negedge clk);
        o_start = tx_start; o_data = tx_data; o_ready = req_ready;
        o_grant = grant_id; o_active = active;
        hs = req_valid & req_ready;
        if (!rst) begin
            chk("ready_onehot", 32'($countones(req_ready) <= 1), 1);
            chk("ready_needs_valid", 32'(req_ready & ~req_valid), 0);
            chk("start_eq_ready", 32'(tx_start), 32'(|req_ready));
            if (frame_open) chk("start_in_frame", 32'(tx_start), 0);
            if (stall_req >= 0 && stall_cnt[stall_req] > 0) begin
                stall_starts += int'(tx_start);
                chk("stall_active", 32'(active), 1);
                chk("stall_grant", 32'(grant_id), 32'(stall_req));
            end
            if (hs != 0) begin
                g = 0;
                for (int i = NR - 1; i >= 0; i--) if (hs[i]) g = i;
                if (owner < 0) begin
                    e = -1;
                    for (int k = 0; k < NR; k++) begin
                        idx = (rr + k) % NR;
                        if (e < 0 && req_valid[idx]) e = idx;
                    end
                    chk("rr_winner", 32'(g), 32'(e));
                    owner = g;
                end else begin
                    chk("packet_lock", 32'(g), 32'(owner));
                end
                chk("grant_id", 32'(grant_id), 32'(g));
                ent = mem[g][head[g]];
                chk("tx_data", 32'(tx_data), 32'(ent[7:0]));
                log_id.push_back(g);
                if (ent[8]) begin
                    rr    = (g + 1) % NR;
                    owner = -1;
                end
            end
            if (tx_start) frame_open = 1'b1;
        end
        @(posedge clk);
        #1;
        fell = 1'b0;
        if (rst) begin
            busy_cnt = 0;
        end else if (o_start) begin
            busy_cnt = BUSY;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) begin
                frame_open = 1'b0;
                fell       = 1'b1;
            end
        end
        tx_busy = (busy_cnt != 0);
        if (!rst) for (int i = 0; i < NR; i++) if (hs[i]) head[i]++;
        for (int i = 0; i < NR; i++) if (stall_cnt[i] > 0) stall_cnt[i]--;
        if (fell && stall_pend && owner == stall_req) begin
            stall_cnt[stall_req] = stall_len;
            stall_pend           = 1'b0;
        end
        drive();
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (n < 3000 && (pending() || active || frame_open)) begin
            step();
            n++;
        end
        chk({tag, "_drain_bound"}, 32'(n < 3000), 1);
    endtask

    task automatic chk_log(input string tag);
        chk({tag, "_count"}, 32'(log_id.size()), 32'(exp_ids.size()));
        for (int i = 0; i < exp_ids.size() && i < log_id.size(); i++)
            chk({tag, "_order"}, 32'(log_id[i]), 32'(exp_ids[i]));
        log_id.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_state();
        drive();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int n, total;
        logic [NR-1:0] m;

        // Reset values
        do_reset();
        step();
        chk("rst_tx_start", 32'(o_start), 0);
        chk("rst_tx_data", 32'(o_data), 0);
        chk("rst_req_ready", 32'(o_ready), 0);
        chk("rst_grant_id", 32'(o_grant), 0);
        chk("rst_active", 32'(o_active), 0);

        // 1. Single request, one-cycle latency
        push(0, 8'h5A, 1'b1);
        drive();
        step();
        chk("t1_idle_start", 32'(o_start), 0);
        chk("t1_idle_active", 32'(o_active), 0);
        step();
        chk("t1_start", 32'(o_start), 1);
        chk("t1_data", 32'(o_data), 32'h5A);
        chk("t1_ready", 32'(o_ready), 32'b0001);
        chk("t1_active", 32'(o_active), 1);
        step();
        chk("t1_ready_drop", 32'(o_ready), 0);
        chk("t1_start_drop", 32'(o_start), 0);
        drain("t1");
        chk("t1_idle_after", 32'(active), 0);
        chk("t1_grant_hold", 32'(grant_id), 0);
        exp_ids = '{0};
        chk_log("t1");
        // rr_ptr must now be 1: requester 1 beats requester 0
        push(0, 8'h01, 1'b1);
        push(1, 8'h02, 1'b1);
        drive();
        drain("t1rr");
        exp_ids = '{1, 0};
        chk_log("t1rr");

        // 2. All four valid after reset
        do_reset();
        for (int i = 0; i < NR; i++) push(i, 8'(8'h10 + i), 1'b1);
        drive();
        drain("t2");
        exp_ids = '{0, 1, 2, 3};
        chk_log("t2");

        // 3. Packet lock against a waiting requester
        push(0, 8'hA0, 1'b0);
        push(0, 8'hA1, 1'b0);
        push(0, 8'hA2, 1'b1);
        push(1, 8'hB0, 1'b1);
        drive();
        drain("t3");
        exp_ids = '{0, 0, 0, 1};
        chk_log("t3");

        // Move rr_ptr to 0 via requester 3
        push(3, 8'hE3, 1'b1);
        drive();
        drain("t4pre");
        exp_ids = '{3};
        chk_log("t4pre");

        // 4. Owner stalls for 5 cycles mid-packet while requester 2 waits
        push(0, 8'hC0, 1'b0);
        push(0, 8'hC1, 1'b1);
        push(2, 8'hD0, 1'b1);
        stall_req = 0; stall_len = 5; stall_pend = 1'b1; stall_starts = 0;
        drive();
        drain("t4");
        chk("t4_stall_applied", 32'(stall_pend), 0);
        chk("t4_no_start_in_stall", 32'(stall_starts), 0);
        exp_ids = '{0, 0, 2};
        chk_log("t4");
        stall_req = -1;

        // 5. Wrap: rr_ptr=3 with requesters 3 and 0
        push(3, 8'h33, 1'b1);
        push(0, 8'h00, 1'b1);
        drive();
        drain("t5");
        exp_ids = '{3, 0};
        chk_log("t5");
        push(0, 8'h40, 1'b1);
        push(1, 8'h41, 1'b1);
        drive();
        drain("t5rr");
        exp_ids = '{1, 0};
        chk_log("t5rr");

        // 6. Reset during WAIT_DONE (rr_ptr is 1 beforehand)
        push(2, 8'h66, 1'b1);
        drive();
        n = 0;
        while (n < 20 && !o_start) begin step(); n++; end
        chk("t6_start_seen", 32'(o_start), 1);
        repeat (4) step();
        rst = 1'b1;
        clear_state();
        drive();
        step();
        step();
        chk("t6_rst_start", 32'(o_start), 0);
        chk("t6_rst_data", 32'(o_data), 0);
        chk("t6_rst_ready", 32'(o_ready), 0);
        chk("t6_rst_grant", 32'(o_grant), 0);
        chk("t6_rst_active", 32'(o_active), 0);
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin step(); n += int'(o_start); end
        chk("t6_no_start_after_rst", 32'(n), 0);
        push(0, 8'h70, 1'b1);
        push(1, 8'h71, 1'b1);
        drive();
        drain("t6");
        exp_ids = '{0, 1};
        chk_log("t6");

        // Randomized packets against the reference model
        for (int r = 0; r < 12; r++) begin
            m = NR'($urandom_range(1, (1 << NR) - 1));
            total = 0;
            for (int i = 0; i < NR; i++) begin
                if (m[i]) begin
                    int len;
                    len = $urandom_range(1, 3);
                    for (int j = 0; j < len; j++) push(i, 8'($urandom), j == len - 1);
                    total += len;
                end
            end
            drive();
            drain("rand");
            chk("rand_all_sent", 32'(log_id.size()), 32'(total));
            log_id.delete();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
